// File: rtl/pc_unit.sv
// pc_unit: fetch PC with trap/branch redirect and stall hold; PC_MISALIGN_CHK_EN adds misalign_o
module pc_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int INC = 4,
  parameter int ALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_enable,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            redirect_o,
`ifdef PC_MISALIGN_CHK_EN
  output logic            misalign_o,
`endif
  output logic            pend_o
);
  typedef enum logic {RUN, HOLD} state_t;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));
  state_t state, state_nx;
  logic [XLEN-1:0] pend_tgt, tgt, tgt_ld;
  logic pend_trap, br_ok, req, redir;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_nx;
  always_comb state_nx = pc_enable ? RUN : (req ? HOLD : state);
  always_comb begin
    pend_o = state == HOLD;
    pc_plus_inc = pc_out + XLEN'(INC);
  end
  always_comb begin
    br_ok = br_valid && !(state == HOLD && pend_trap);
    req = trap_valid || br_ok;
    tgt = trap_valid ? trap_target : (br_ok ? br_target : pend_tgt);
    redir = pc_enable && (req || state == HOLD);
`ifdef PC_MISALIGN_CHK_EN
    tgt_ld = tgt & ALIGN_MASK;
`else
    tgt_ld = tgt;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_out <= RESET_VEC;
      redirect_o <= 1'b0;
      pend_tgt <= '0;
      pend_trap <= 1'b0;
    end else begin
      if (pc_enable) pc_out <= redir ? tgt_ld : pc_plus_inc;
      redirect_o <= redir;
      pend_tgt <= pc_enable ? '0 : (req ? tgt : pend_tgt);
      pend_trap <= pc_enable ? 1'b0 : (req ? trap_valid : pend_trap);
    end
`ifdef PC_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) misalign_o <= 1'b0;
    else if (redir) misalign_o <= |(tgt & ~ALIGN_MASK);
`endif
endmodule
